uart_receiver_interface: RTL
============================

// Module: uart_receiver_interface
// PURPOSE
//  System-bus responder that deserialises an 8N1 UART RX line into a byte FIFO.
//  Inbound counterpart of uart_transmitter_interface; decoded in the same 4'h2 peripheral region.
//  Exposes a status register and a data register.
//  Software polls status and pops received bytes with bus reads.
// PARAMETERS
//  CLK_FREQ         100_000_000  system clock frequency, Hz
//  BAUD_RATE        115_200      line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (truncated, >= 4)
//  FIFO_DEPTH_LOG2  4            FIFO depth = 2**FIFO_DEPTH_LOG2 entries of 8 bits
// PORTS
//  clk              in   1   system clock
//  reset_n          in   1   asynchronous active-low reset
//  addr             in   1   register select: 0 = STATUS, 1 = DATA (bus addr[2])
//  write_data       in   32  write data
//  byte_enable      in   4   byte enables; only [0] is used
//  write_req        in   1   single-cycle write strobe
//  read_req         in   1   single-cycle read strobe
//  read_data        out  32  read data, valid with read_data_valid
//  read_data_valid  out  1   one-cycle pulse, exactly 1 cycle after read_req
//  rx               in   1   asynchronous serial input, idle high
// BEHAVIOUR
//  - Block is always ready: no back-pressure. Reset values: read_data=0, read_data_valid=0, flags=0,
//    FIFO empty, FSM in IDLE, rx synchroniser flops=1.
//  - rx passes through a 2-flop synchroniser; all decoding uses the synchronised value.
//  - FSM states:
//    IDLE:  on a falling edge, load counter with CLKS_PER_BIT/2 -> START.
//    START: at count 0, if rx=0 -> DATA; otherwise (glitch) -> IDLE with no flags set.
//    DATA:  samples every CLKS_PER_BIT, LSB first; after 8 bits -> PARITY if enabled, else -> STOP.
//    STOP:  samples one bit. rx=1 -> push byte. rx=0 -> set FRAME_ERR, drop byte.
//           Then -> IDLE immediately; no wait for line idle.
//  - Push when FIFO full: byte dropped, OVERRUN set, FIFO contents unchanged.
//  - Pop and push in the same cycle: pop is applied first, so a push into a full FIFO succeeds.
//  - STATUS read: [0]=not empty, [1]=OVERRUN, [2]=FRAME_ERR, [3]=PARITY_ERR,
//    [15:8]=FIFO count (zero-extended), other bits 0.
//  - DATA read: returns {24'h0, head byte} and pops. When empty, returns 0 and does not pop.
//  - STATUS write with byte_enable[0]: write-1-to-clear on bits [3:1]. Other writes are ignored.
//    A flag set in the same cycle as its clear stays set (set wins).
//  - read_req and write_req together: both are serviced.
//  - FIFO pointers are FIFO_DEPTH_LOG2+1 bits wide (wrap bit); count = wr_ptr - rd_ptr, modulo.
//  - reset_n asserted mid-frame: FSM returns to IDLE and the partial byte is discarded.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    - Frame is 8E1. PARITY state samples one bit after DATA.
//    - A mismatch with even parity of the data sets PARITY_ERR and drops the byte, even if the stop bit is good.
//  UART_RX_PARITY_EN undefined:
//    - No PARITY state; frame is 8N1.
//    - STATUS[3] reads 0 and writes to it have no effect.
// STRUCTURE
//  - uart_pkg holds:
//    - rx_state_t enum (IDLE, START, DATA, PARITY, STOP);
//    - register offsets REG_STATUS=1'b0 and REG_DATA=1'b1;
//    - STATUS bit index constants.
//  - Sub-module uart_rx_fifo (parameter DEPTH_LOG2): synchronous push/pop with full, empty and count.
//    It is a candidate for reuse by the transmitter.
// TESTING (CLK_FREQ=100e6, BAUD_RATE=115200 -> 868 clk/bit, FIFO_DEPTH_LOG2=4)
//  - Send 0xA5 8N1 -> STATUS read = 0x0000_0101; DATA read = 0x0000_00A5; STATUS then = 0x0.
//  - rx low for 200 cycles, then high -> no push; STATUS = 0x0.
//  - Send 0x3C with stop bit 0 -> STATUS = 0x4. Write STATUS 0x4 -> STATUS = 0x0.
//  - Send 17 bytes 0x00..0x10 without reading -> STATUS = 0x0000_1003.
//    16 DATA reads return 0x00..0x0F; a 17th DATA read returns 0.
//  - Assert reset_n for 1 cycle during bit 4 of a frame, then send 0x5A -> only 0x5A is received.
//  - UART_RX_PARITY_EN: send 0x01 with parity bit 0 -> PARITY_ERR set, FIFO empty.
//    Send 0x01 with parity bit 1 -> byte 0x01 received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver bus interface.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_t;

    localparam logic REG_STATUS = 1'b0;
    localparam logic REG_DATA   = 1'b1;

    localparam int unsigned STAT_NOT_EMPTY  = 0;
    localparam int unsigned STAT_OVERRUN    = 1;
    localparam int unsigned STAT_FRAME_ERR  = 2;
    localparam int unsigned STAT_PARITY_ERR = 3;
    localparam int unsigned STAT_COUNT_LSB  = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO with wrap-bit pointers; a pop in the same cycle frees room for a push into a full FIFO.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [7:0]            wdata_i,
    input  logic                  pop_i,
    output logic [7:0]            rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    logic [7:0]          mem_q [Depth];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic                do_push, do_pop;

    always_comb begin
        count_o  = wr_ptr_q - rd_ptr_q;
        empty_o  = (count_o == '0);
        full_o   = (count_o == (DEPTH_LOG2 + 1)'(Depth));
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rdata_o  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_receiver_interface.sv
// Bus-polled UART receiver: 8N1 deserialiser feeding a byte FIFO with STATUS/DATA registers.
// Define UART_RX_PARITY_EN for 8E1 frames with a PARITY_ERR flag.
module uart_receiver_interface
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ        = 100_000_000,
    parameter int unsigned BAUD_RATE       = 115_200,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        addr,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_enable,
    input  logic        write_req,
    input  logic        read_req,
    output logic [31:0] read_data,
    output logic        read_data_valid,
    input  logic        rx
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfBit  = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0] FullBit  = CntW'(CLKS_PER_BIT - 1);

    rx_state_t           state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [7:0]          shreg_q, shreg_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [1:0]          rx_sync_q;
    logic                rx_prev_q;
    logic                rx_s, cnt_zero;
    logic                overrun_q, overrun_d;
    logic                frame_err_q, frame_err_d;
    logic                parity_err;
    logic [31:0]         read_data_d;
    logic                read_data_valid_d;
    logic                push_req, frame_set, parity_set;
    logic                clr, pop;
    logic [31:0]         status;
    logic [7:0]          fifo_rdata;
    logic                fifo_full, fifo_empty;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;
    logic                unused_bits;

`ifdef UART_RX_PARITY_EN
    logic parity_bad_q, parity_bad_d;
    logic parity_err_q, parity_err_d;
    assign unused_bits = ^{write_data[31:4], write_data[0], byte_enable[3:1]};
`else
    assign unused_bits = ^{write_data[31:3], write_data[0], byte_enable[3:1]};
`endif

    assign rx_s     = rx_sync_q[1];
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            rx_sync_q <= 2'b11;
            rx_prev_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            rx_sync_q <= {rx_sync_q[0], rx};
            rx_prev_q <= rx_sync_q[1];
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= parity_bad_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
`endif
        case (state_q)
            StIdle: begin
                if (rx_prev_q && !rx_s) begin
                    cnt_d   = HalfBit;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rx_s) begin
                    cnt_d     = FullBit;
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                end else begin
                    state_d = StIdle;
                end
            end
            StData: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shreg_d   = {rx_s, shreg_q[7:1]};
                    cnt_d     = FullBit;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    parity_bad_d = rx_s ^ (^shreg_q);
                    cnt_d        = FullBit;
                    state_d      = StStop;
                end
            end
`endif
            StStop: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Stop-bit outcome: a bad stop or bad parity drops the byte.
    always_comb begin
        push_req   = 1'b0;
        frame_set  = 1'b0;
        parity_set = 1'b0;
        if (state_q == StStop && cnt_zero) begin
            frame_set = !rx_s;
`ifdef UART_RX_PARITY_EN
            parity_set = parity_bad_q;
            push_req   = rx_s && !parity_bad_q;
`else
            push_req   = rx_s;
`endif
        end
    end

    uart_rx_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (push_req),
        .wdata_i (shreg_q),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        clr         = write_req && (addr == REG_STATUS) && byte_enable[0];
        pop         = read_req && (addr == REG_DATA);
        overrun_d   = (overrun_q & ~(clr & write_data[STAT_OVERRUN]))
                    | (push_req & fifo_full & ~(pop & ~fifo_empty));
        frame_err_d = (frame_err_q & ~(clr & write_data[STAT_FRAME_ERR])) | frame_set;
`ifdef UART_RX_PARITY_EN
        parity_err_d = (parity_err_q & ~(clr & write_data[STAT_PARITY_ERR])) | parity_set;
        parity_err   = parity_err_q;
`else
        parity_err   = parity_set;
`endif

        status                 = '0;
        status[STAT_NOT_EMPTY] = !fifo_empty;
        status[STAT_OVERRUN]   = overrun_q;
        status[STAT_FRAME_ERR] = frame_err_q;
        status[STAT_PARITY_ERR] = parity_err;
        status[STAT_COUNT_LSB +: 8] = 8'(fifo_count);

        read_data_valid_d = read_req;
        read_data_d       = '0;
        if (read_req) begin
            if (addr == REG_STATUS) begin
                read_data_d = status;
            end else if (!fifo_empty) begin
                read_data_d = {24'h0, fifo_rdata};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q       <= 1'b0;
            frame_err_q     <= 1'b0;
            read_data       <= '0;
            read_data_valid <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q    <= 1'b0;
`endif
        end else begin
            overrun_q       <= overrun_d;
            frame_err_q     <= frame_err_d;
            read_data       <= read_data_d;
            read_data_valid <= read_data_valid_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q    <= parity_err_d;
`endif
        end
    end

endmodule
